conv11_weight_buffer: RTL and testbench

Parametrised weight store for the 1x1 convolution layer. Holds a full OUT_CH x IN_CH weight matrix.
- Loading: one weight per cycle over a serial byte stream.
- Reading: one output-channel row of IN_CH weights per read request, packed on a wide bus for the parallel 1x1 MAC array.
- Successor to the single-weight loader: adds depth, channel parallelism, row sequencing and reload control.

---
 rtl/conv11_weight_buffer.sv | 115 +++++++++++
 tb/tb_conv11_weight_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv11_weight_buffer.sv
// 1x1 convolution weight store: serial byte-stream load, one output-channel row per read.
// Optional CONV11_WBUF_RELOAD_EN adds a reload input that restarts loading without rst.
module conv11_weight_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IN_CH      = 4,
    parameter int unsigned OUT_CH     = 4,
    localparam int unsigned OC_W      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef CONV11_WBUF_RELOAD_EN
    input  logic                        reload,
`endif
    input  logic                        load_en,
    input  logic [DATA_WIDTH-1:0]       load_data,
    input  logic                        read_en,
    output logic [IN_CH*DATA_WIDTH-1:0] weight_row,
    output logic [OC_W-1:0]             oc_idx,
    output logic                        valid,
    output logic                        row_last,
    output logic                        weight_load,
    output logic                        loaded
);

    localparam int unsigned DEPTH = OUT_CH * IN_CH;
    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(OUT_CH - 1);

    typedef enum logic {StLoad, StReady} state_e;

    state_e                        state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [OC_W-1:0]               rd_ptr_q;
    logic [DATA_WIDTH-1:0]         mem [DEPTH];
    logic                          reload_w;
    logic                          mem_we;
    logic [CNT_W-1:0]              row_base;
    logic [IN_CH*DATA_WIDTH-1:0]   row_d;

`ifdef CONV11_WBUF_RELOAD_EN
    assign reload_w = reload;
`else
    assign reload_w = 1'b0;
`endif

    assign mem_we = (state_q == StLoad) && load_en && !rst && !reload_w;

    // Storage has no reset; a restarted load simply overwrites from index 0.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cnt_q] <= load_data;
        end
    end

    always_comb begin
        row_base = CNT_W'(rd_ptr_q * IN_CH);
        row_d    = '0;
        for (int unsigned ic = 0; ic < IN_CH; ic++) begin
            row_d[ic*DATA_WIDTH +: DATA_WIDTH] = mem[row_base + CNT_W'(ic)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            weight_row  <= '0;
            oc_idx      <= '0;
            valid       <= 1'b0;
            row_last    <= 1'b0;
            weight_load <= 1'b0;
            loaded      <= 1'b0;
        end else if (reload_w) begin
            // Row outputs keep their last values; only control state restarts.
            state_q     <= StLoad;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            valid       <= 1'b0;
            row_last    <= 1'b0;
            weight_load <= 1'b0;
            loaded      <= 1'b0;
        end else begin
            valid       <= 1'b0;
            row_last    <= 1'b0;
            weight_load <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    if (load_en) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= StReady;
                            cnt_q       <= '0;
                            loaded      <= 1'b1;
                            weight_load <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StReady: begin
                    if (read_en) begin
                        weight_row <= row_d;
                        oc_idx     <= rd_ptr_q;
                        valid      <= 1'b1;
                        row_last   <= (rd_ptr_q == OC_LAST);
                        rd_ptr_q   <= (rd_ptr_q == OC_LAST) ? '0 : rd_ptr_q + 1'b1;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_conv11_weight_buffer.sv
// Scoreboard bench for conv11_weight_buffer (IN_CH=2, OUT_CH=3); reads queue expected rows.
module tb_conv11_weight_buffer;

    localparam int unsigned DW     = 8;
    localparam int unsigned IN_CH  = 2;
    localparam int unsigned OUT_CH = 3;
    localparam int unsigned OC_W   = 2;
    localparam int unsigned DEPTH  = IN_CH * OUT_CH;

    typedef struct packed {
        logic [IN_CH*DW-1:0] row;
        logic [OC_W-1:0]     oc;
        logic                last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  reload = 1'b0;
    logic                  load_en = 1'b0;
    logic [DW-1:0]         load_data = '0;
    logic                  read_en = 1'b0;
    logic [IN_CH*DW-1:0]   weight_row;
    logic [OC_W-1:0]       oc_idx;
    logic                  valid;
    logic                  row_last;
    logic                  weight_load;
    logic                  loaded;

    conv11_weight_buffer #(
        .DATA_WIDTH (DW),
        .IN_CH      (IN_CH),
        .OUT_CH     (OUT_CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CONV11_WBUF_RELOAD_EN
        .reload      (reload),
`endif
        .load_en     (load_en),
        .load_data   (load_data),
        .read_en     (read_en),
        .weight_row  (weight_row),
        .oc_idx      (oc_idx),
        .valid       (valid),
        .row_last    (row_last),
        .weight_load (weight_load),
        .loaded      (loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0]       m_mem [DEPTH];
    bit                  m_ready = 1'b0;
    int                  m_cnt = 0;
    int                  m_ptr = 0;
    logic [IN_CH*DW-1:0] exp_row = '0;
    logic [OC_W-1:0]     exp_oc = '0;
    logic                exp_wl = 1'b0;
    logic                exp_loaded = 1'b0;
    bit                  mon_en = 1'b0;
    exp_t                exp_q[$];

    // One clock cycle of stimulus; model predicts outputs after the coming edge.
    task automatic cycle(input logic ld, input logic [DW-1:0] d, input logic rd,
                         input logic rs, input logic rl);
        exp_t e;
        @(negedge clk);
        #1;
        load_en   = ld;
        load_data = d;
        read_en   = rd;
        rst       = rs;
        reload    = rl;
`ifndef CONV11_WBUF_RELOAD_EN
        rl = 1'b0;
`endif
        exp_wl = 1'b0;
        if (rs) begin
            m_ready = 1'b0; m_cnt = 0; m_ptr = 0;
            exp_row = '0; exp_oc = '0; exp_loaded = 1'b0;
        end else if (rl) begin
            m_ready = 1'b0; m_cnt = 0; m_ptr = 0; exp_loaded = 1'b0;
        end else if (m_ready) begin
            if (rd) begin
                for (int ic = 0; ic < int'(IN_CH); ic++)
                    e.row[ic*DW +: DW] = m_mem[m_ptr*IN_CH + ic];
                e.oc   = OC_W'(m_ptr);
                e.last = (m_ptr == OUT_CH - 1);
                exp_q.push_back(e);
                exp_row = e.row;
                exp_oc  = e.oc;
                m_ptr   = (m_ptr == OUT_CH - 1) ? 0 : m_ptr + 1;
            end
        end else if (ld) begin
            m_mem[m_cnt] = d;
            if (m_cnt == DEPTH - 1) begin
                m_ready = 1'b1; m_cnt = 0; exp_wl = 1'b1; exp_loaded = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check_eq("valid", valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (valid) begin
                    check_eq("row", weight_row, e.row);
                    check_eq("oc_idx", oc_idx, e.oc);
                    check_eq("row_last", row_last, e.last);
                end
            end else begin
                check_eq("row_last_idle", row_last, 1'b0);
            end
            check_eq("row_hold", weight_row, exp_row);
            check_eq("oc_hold", oc_idx, exp_oc);
            check_eq("weight_load", weight_load, exp_wl);
            check_eq("loaded", loaded, exp_loaded);
        end
    end

    task automatic load_seq(input int first, input int step, input bit gaps, input bit rd);
        for (int i = 0; i < int'(DEPTH); i++) begin
            cycle(1'b1, DW'(first + i*step), rd, 1'b0, 1'b0);
            if (gaps) cycle(1'b0, 8'h00, rd, 1'b0, 1'b0);
        end
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        mon_en = 1'b1;
        idle(1);

        // Basic load, then two full passes of reads
        load_seq(1, 1, 1'b0, 1'b0);
        idle(1);
        reads(6);
        idle(1);

        // Loads after completion are ignored
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        reads(3);
        idle(1);

        // read_en held throughout the load, including the final weight
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        load_seq(1, 1, 1'b0, 1'b1);
        reads(2);
        idle(1);

        // Reset mid-load discards partial data
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(7 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        load_seq(10, 1, 1'b0, 1'b0);
        reads(3);
        idle(1);

        // Gapped load of negative weights
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        load_seq(255, -1, 1'b1, 1'b0);
        reads(3);
        idle(1);

`ifdef CONV11_WBUF_RELOAD_EN
        // Reload mid-read; simultaneous load/read are dropped
        reads(2);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        idle(1);
        load_seq(20, 1, 1'b0, 1'b0);
        reads(3);
        idle(1);
`endif

        idle(2);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
